// File: rtl/ppu_pkg.sv
// Shared PPU definitions: LCD mode encoding, VRAM window and the VRAM arbiter's
// state and requester encodings.
package ppu_pkg;

  typedef enum logic [1:0] {
    HBLANK   = 2'd0,
    VBLANK   = 2'd1,
    OAM_SCAN = 2'd2,
    DRAWING  = 2'd3
  } ppu_mode_t;

  localparam logic [15:0] VRAM_BASE = 16'h8000;
  localparam logic [15:0] VRAM_END  = 16'h9FFF;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_READ  = 2'd1,
    ARB_WRITE = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    SRC_BG  = 2'd0,
    SRC_SPR = 2'd1,
    SRC_CPU = 2'd2
  } req_src_t;

endpackage

// File: rtl/ppu_vram_arbiter.sv
// Single-port VRAM arbiter for the background fetcher, sprite fetcher and CPU,
// enforcing the mode-3 lockout rules with one access in flight at a time.
module ppu_vram_arbiter #(
  parameter logic [15:0] VRAM_BASE    = ppu_pkg::VRAM_BASE,
  parameter int          VRAM_DEPTH   = 8192,
  parameter int          READ_LATENCY = 2
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [1:0]                    ppu_mode_in,
  input  logic [15:0]                   bg_addr_in,
  input  logic                          bg_addr_valid_in,
  input  logic                          bg_busy_in,
  output logic [7:0]                    bg_data_out,
  output logic                          bg_data_valid_out,
  input  logic [15:0]                   spr_addr_in,
  input  logic                          spr_addr_valid_in,
  output logic [7:0]                    spr_data_out,
  output logic                          spr_data_valid_out,
  input  logic [15:0]                   cpu_addr_in,
  input  logic                          cpu_req_in,
  input  logic                          cpu_we_in,
  input  logic [7:0]                    cpu_wdata_in,
  output logic [7:0]                    cpu_rdata_out,
  output logic                          cpu_done_out,
  output logic [$clog2(VRAM_DEPTH)-1:0] vram_addr_out,
  output logic                          vram_we_out,
  output logic [7:0]                    vram_wdata_out,
  input  logic [7:0]                    vram_rdata_in
);
  import ppu_pkg::*;

  localparam int AW = $clog2(VRAM_DEPTH);
  localparam int CW = (READ_LATENCY < 1) ? 1 : $clog2(READ_LATENCY + 1);
  localparam logic [CW-1:0] CNT_CAPTURE = CW'(READ_LATENCY - 1);
  localparam logic [CW-1:0] CNT_LAST    = CW'(READ_LATENCY);

  function automatic logic in_vram(input logic [15:0] a);
    return (int'(a) >= int'(VRAM_BASE)) && (int'(a) < int'(VRAM_BASE) + VRAM_DEPTH);
  endfunction

  function automatic logic [AW-1:0] vram_offset(input logic [15:0] a);
    return AW'(a - VRAM_BASE);
  endfunction

  arb_state_t    state;
  req_src_t      gnt;
  logic [CW-1:0] cnt;
  logic [15:0]   acc_addr;
  logic [1:0]    mode_reg;

  // Requests are registered so every requester is arbitrated one edge after it is seen.
  logic          bg_req_reg, spr_req_reg;
  logic [15:0]   bg_addr_reg, spr_addr_reg;
  logic [15:0]   bg_held, spr_held;

  logic          cpu_pend, cpu_blk, cpu_we_reg;
  logic [15:0]   cpu_addr_reg;
  logic [7:0]    cpu_wdata_reg;

  logic drawing, bg_srv, spr_srv;
  logic bg_pend, spr_pend, bg_imm, spr_imm, bg_cand, spr_cand;
  logic cpu_imm, cpu_cand;
  logic grant_bg, grant_spr, grant_cpu;

  always_comb begin
    drawing  = (mode_reg == DRAWING);
    bg_srv   = (state != ARB_IDLE) && (gnt == SRC_BG);
    spr_srv  = (state != ARB_IDLE) && (gnt == SRC_SPR);
    // A result already held for the same address satisfies the request.
    bg_pend  = bg_req_reg && !(bg_data_valid_out && bg_held == bg_addr_reg) && !bg_srv;
    spr_pend = spr_req_reg && !(spr_data_valid_out && spr_held == spr_addr_reg) && !spr_srv;
    bg_imm   = bg_pend && (!drawing || !in_vram(bg_addr_reg));
    spr_imm  = spr_pend && (!drawing || !in_vram(spr_addr_reg));
    bg_cand  = bg_pend && !bg_imm;
    spr_cand = spr_pend && !spr_imm;
    cpu_imm  = cpu_pend && cpu_blk;
    cpu_cand = cpu_pend && !cpu_blk && !drawing;

    grant_bg  = 1'b0;
    grant_spr = 1'b0;
    grant_cpu = 1'b0;
    if (state == ARB_IDLE) begin
      if (drawing) begin
        if (bg_busy_in) begin
          grant_bg  = bg_cand;
          grant_spr = !bg_cand && spr_cand;
        end else begin
          grant_spr = spr_cand;
          grant_bg  = !spr_cand && bg_cand;
        end
      end else begin
        grant_cpu = cpu_cand;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state              <= ARB_IDLE;
      gnt                <= SRC_BG;
      cnt                <= '0;
      acc_addr           <= '0;
      mode_reg           <= '0;
      bg_req_reg         <= 1'b0;
      spr_req_reg        <= 1'b0;
      bg_addr_reg        <= '0;
      spr_addr_reg       <= '0;
      bg_held            <= '0;
      spr_held           <= '0;
      cpu_pend           <= 1'b0;
      cpu_blk            <= 1'b0;
      cpu_we_reg         <= 1'b0;
      cpu_addr_reg       <= '0;
      cpu_wdata_reg      <= '0;
      bg_data_out        <= '0;
      bg_data_valid_out  <= 1'b0;
      spr_data_out       <= '0;
      spr_data_valid_out <= 1'b0;
      cpu_rdata_out      <= '0;
      cpu_done_out       <= 1'b0;
      vram_addr_out      <= '0;
      vram_we_out        <= 1'b0;
      vram_wdata_out     <= '0;
    end else begin
      mode_reg     <= ppu_mode_in;
      bg_req_reg   <= bg_addr_valid_in;
      bg_addr_reg  <= bg_addr_in;
      spr_req_reg  <= spr_addr_valid_in;
      spr_addr_reg <= spr_addr_in;
      cpu_done_out <= 1'b0;
      vram_we_out  <= 1'b0;

      // Release a held result on withdrawal or when the fetcher moves to a new address.
      if (!bg_addr_valid_in || bg_addr_in != bg_held)
        bg_data_valid_out <= 1'b0;
      if (!spr_addr_valid_in || spr_addr_in != spr_held)
        spr_data_valid_out <= 1'b0;

      if (bg_imm) begin
        bg_data_out       <= 8'hFF;
        bg_data_valid_out <= 1'b1;
        bg_held           <= bg_addr_reg;
      end
      if (spr_imm) begin
        spr_data_out       <= 8'hFF;
        spr_data_valid_out <= 1'b1;
        spr_held           <= spr_addr_reg;
      end

      // Lockout is decided from the mode at the moment the CPU asks.
      if (cpu_req_in && !cpu_pend) begin
        cpu_pend      <= 1'b1;
        cpu_blk       <= (ppu_mode_in == DRAWING) || !in_vram(cpu_addr_in);
        cpu_we_reg    <= cpu_we_in;
        cpu_addr_reg  <= cpu_addr_in;
        cpu_wdata_reg <= cpu_wdata_in;
      end
      if (cpu_imm) begin
        cpu_rdata_out <= 8'hFF;
        cpu_done_out  <= 1'b1;
        cpu_pend      <= 1'b0;
      end

      case (state)
        ARB_IDLE: begin
          if (grant_bg || grant_spr) begin
            state         <= ARB_READ;
            cnt           <= '0;
            gnt           <= grant_bg ? SRC_BG : SRC_SPR;
            acc_addr      <= grant_bg ? bg_addr_reg : spr_addr_reg;
            vram_addr_out <= vram_offset(grant_bg ? bg_addr_reg : spr_addr_reg);
          end else if (grant_cpu) begin
            gnt           <= SRC_CPU;
            vram_addr_out <= vram_offset(cpu_addr_reg);
            if (cpu_we_reg) begin
              state          <= ARB_WRITE;
              vram_we_out    <= 1'b1;
              vram_wdata_out <= cpu_wdata_reg;
            end else begin
              state <= ARB_READ;
              cnt   <= '0;
            end
          end
        end
        ARB_READ: begin
          // Data is captured one count before the FSM returns to Idle.
          if (cnt == CNT_LAST) begin
            state <= ARB_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_CAPTURE) begin
              case (gnt)
                SRC_BG: begin
                  bg_data_out       <= vram_rdata_in;
                  bg_data_valid_out <= 1'b1;
                  bg_held           <= acc_addr;
                end
                SRC_SPR: begin
                  spr_data_out       <= vram_rdata_in;
                  spr_data_valid_out <= 1'b1;
                  spr_held           <= acc_addr;
                end
                default: begin
                  cpu_rdata_out <= vram_rdata_in;
                  cpu_done_out  <= 1'b1;
                  cpu_pend      <= 1'b0;
                end
              endcase
            end
          end
        end
        ARB_WRITE: begin
          state        <= ARB_IDLE;
          cpu_done_out <= 1'b1;
          cpu_pend     <= 1'b0;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ppu_vram_arbiter.sv
// Randomized bench for ppu_vram_arbiter: a behavioural VRAM/access-rule model
// predicts data, latency and write side effects for every transaction.
module tb_ppu_vram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  ppu_mode = 2'd0;
  logic [15:0] bg_addr = '0;
  logic        bg_valid = 1'b0;
  logic        bg_busy = 1'b0;
  logic [7:0]  bg_data;
  logic        bg_data_valid;
  logic [15:0] spr_addr = '0;
  logic        spr_valid = 1'b0;
  logic [7:0]  spr_data;
  logic        spr_data_valid;
  logic [15:0] cpu_addr = '0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [7:0]  cpu_wdata = '0;
  logic [7:0]  cpu_rdata;
  logic        cpu_done;
  logic [12:0] vram_addr;
  logic        vram_we;
  logic [7:0]  vram_wdata;
  logic [7:0]  rdata_q;

  int checks = 0;
  int errors = 0;
  int txn = 0;

  always #5 clk = ~clk;

  ppu_vram_arbiter dut (
    .clk_in             (clk),
    .rst_in             (rst),
    .ppu_mode_in        (ppu_mode),
    .bg_addr_in         (bg_addr),
    .bg_addr_valid_in   (bg_valid),
    .bg_busy_in         (bg_busy),
    .bg_data_out        (bg_data),
    .bg_data_valid_out  (bg_data_valid),
    .spr_addr_in        (spr_addr),
    .spr_addr_valid_in  (spr_valid),
    .spr_data_out       (spr_data),
    .spr_data_valid_out (spr_data_valid),
    .cpu_addr_in        (cpu_addr),
    .cpu_req_in         (cpu_req),
    .cpu_we_in          (cpu_we),
    .cpu_wdata_in       (cpu_wdata),
    .cpu_rdata_out      (cpu_rdata),
    .cpu_done_out       (cpu_done),
    .vram_addr_out      (vram_addr),
    .vram_we_out        (vram_we),
    .vram_wdata_out     (vram_wdata),
    .vram_rdata_in      (rdata_q)
  );

  function automatic logic [7:0] init_val(input int i);
    if (i == 32'h1800) return 8'h2A;
    return 8'(i * 29 + (i >> 7) + 3);
  endfunction

  // VRAM block with a registered read port.
  logic [7:0] mem [0:8191];
  bit mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 8192; i++) mem[i] <= init_val(i);
      mem_ready <= 1'b1;
    end else if (vram_we) begin
      mem[vram_addr] <= vram_wdata;
    end
    rdata_q <= mem[vram_addr];
  end

  int          we_cnt = 0;
  logic [12:0] we_addr = '0;
  logic [7:0]  we_data = '0;
  always @(posedge clk) begin
    if (vram_we) begin
      we_cnt  <= we_cnt + 1;
      we_addr <= vram_addr;
      we_data <= vram_wdata;
    end
  end

  // Reference model state: what VRAM should contain.
  logic [7:0] ref_mem [0:8191];

  function automatic bit in_rng(input logic [15:0] a);
    return (a >= 16'h8000) && (a <= 16'h9FFF);
  endfunction

  function automatic int off(input logic [15:0] a);
    return int'(a) - 32'h8000;
  endfunction

  function automatic logic [15:0] rand_addr();
    if ($urandom_range(0, 4) == 0)
      return ($urandom_range(0, 1) == 1) ? 16'($urandom_range(16'hA000, 16'hFFFF))
                                         : 16'($urandom_range(0, 16'h7FFF));
    return 16'($urandom_range(16'h8000, 16'h9FFF));
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_txn(input bit spr, input logic [15:0] addr, input logic [1:0] mode,
                           input bit switch_mode);
    int n;
    int exp_n;
    bit served;
    bit got_v;
    logic [7:0] exp_d;
    logic [7:0] got_d;
    served = (mode == 2'd3) && in_rng(addr);
    exp_n  = served ? 4 : 2;
    exp_d  = served ? ref_mem[off(addr)] : 8'hFF;
    ppu_mode = mode;
    if (spr) begin spr_addr = addr; spr_valid = 1'b1; end
    else     begin bg_addr = addr;  bg_valid = 1'b1;  end
    n = 0;
    got_v = 1'b0;
    got_d = '0;
    while (!got_v && n < 20) begin
      tick();
      n++;
      if (n == 2 && served) begin
        check("vram_addr", 32'(vram_addr), off(addr));
        if (switch_mode) ppu_mode = 2'd0;
      end
      got_v = spr ? spr_data_valid : bg_data_valid;
      got_d = spr ? spr_data : bg_data;
    end
    check(spr ? "spr_latency" : "bg_latency", n, exp_n);
    check(spr ? "spr_data" : "bg_data", got_d, exp_d);
    tick();
    tick();
    if (spr) check("spr_hold", {spr_data_valid, spr_data}, {1'b1, exp_d});
    else     check("bg_hold", {bg_data_valid, bg_data}, {1'b1, exp_d});
    bg_valid = 1'b0;
    spr_valid = 1'b0;
    tick();
    check(spr ? "spr_clear" : "bg_clear", spr ? spr_data_valid : bg_data_valid, 1'b0);
    txn++;
    $display("txn %0d %s addr=%h mode=%0d data=%h lat=%0d", txn, spr ? "spr" : "bg",
             addr, mode, got_d, n);
    tick();
    tick();
  endtask

  task automatic pair_txn(input bit busy, input logic [15:0] a_bg, input logic [15:0] a_spr);
    int n;
    int bg_n;
    int spr_n;
    int slot;
    int exp_bg;
    int exp_spr;
    logic [7:0] bg_d, spr_d, exp_bg_d, exp_spr_d;
    exp_bg_d  = in_rng(a_bg) ? ref_mem[off(a_bg)] : 8'hFF;
    exp_spr_d = in_rng(a_spr) ? ref_mem[off(a_spr)] : 8'hFF;
    // In-range requests are served back to back in priority order; others answer at once.
    slot = 0;
    if (busy) begin
      exp_bg = in_rng(a_bg) ? 4 + 4 * slot : 2;
      if (in_rng(a_bg)) slot++;
      exp_spr = in_rng(a_spr) ? 4 + 4 * slot : 2;
    end else begin
      exp_spr = in_rng(a_spr) ? 4 + 4 * slot : 2;
      if (in_rng(a_spr)) slot++;
      exp_bg = in_rng(a_bg) ? 4 + 4 * slot : 2;
    end
    ppu_mode = 2'd3;
    bg_busy = busy;
    bg_addr = a_bg;
    spr_addr = a_spr;
    bg_valid = 1'b1;
    spr_valid = 1'b1;
    n = 0; bg_n = 0; spr_n = 0; bg_d = '0; spr_d = '0;
    while ((bg_n == 0 || spr_n == 0) && n < 24) begin
      tick();
      n++;
      if (bg_n == 0 && bg_data_valid) begin bg_n = n; bg_d = bg_data; end
      if (spr_n == 0 && spr_data_valid) begin spr_n = n; spr_d = spr_data; end
    end
    check("pair_bg_latency", bg_n, exp_bg);
    check("pair_spr_latency", spr_n, exp_spr);
    check("pair_bg_data", bg_d, exp_bg_d);
    check("pair_spr_data", spr_d, exp_spr_d);
    check("pair_hold", {bg_data_valid, spr_data_valid, bg_data, spr_data},
          {2'b11, exp_bg_d, exp_spr_d});
    bg_valid = 1'b0;
    spr_valid = 1'b0;
    tick();
    check("pair_clear", {bg_data_valid, spr_data_valid}, 2'b00);
    txn++;
    $display("txn %0d pair busy=%0d bg=%h@%0d spr=%h@%0d", txn, busy, a_bg, bg_n, a_spr, spr_n);
    bg_busy = 1'b0;
    tick();
    tick();
  endtask

  task automatic cpu_txn(input bit we, input logic [15:0] addr, input logic [7:0] wd,
                         input logic [1:0] mode);
    bit blocked;
    bit exp_we;
    int n;
    int exp_n;
    int w0;
    logic [7:0] exp_d;
    blocked = (mode == 2'd3) || !in_rng(addr);
    exp_we  = we && !blocked;
    exp_n   = blocked ? 2 : (we ? 3 : 4);
    exp_d   = blocked ? 8'hFF : ref_mem[off(addr)];
    w0 = we_cnt;
    ppu_mode = mode;
    cpu_addr = addr;
    cpu_we = we;
    cpu_wdata = wd;
    cpu_req = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
      if (n == 1) cpu_req = 1'b0;
      if (n == 2) check("cpu_we_pulse", vram_we, exp_we);
    end while (!cpu_done && n < 20);
    check("cpu_latency", n, exp_n);
    if (!we || blocked) check("cpu_rdata", cpu_rdata, exp_d);
    tick();
    check("cpu_done_pulse", cpu_done, 1'b0);
    check("cpu_we_count", we_cnt - w0, 32'(exp_we));
    if (exp_we) begin
      check("cpu_we_addr", 32'(we_addr), off(addr));
      check("cpu_we_data", we_data, wd);
      ref_mem[off(addr)] = wd;
    end
    txn++;
    $display("txn %0d cpu %s addr=%h mode=%0d wdata=%h rdata=%h lat=%0d", txn,
             we ? "wr" : "rd", addr, mode, wd, cpu_rdata, n);
    tick();
    tick();
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) ref_mem[i] = init_val(i);
    repeat (3) tick();
    check("rst_bg", {bg_data_valid, bg_data}, 9'h000);
    check("rst_spr", {spr_data_valid, spr_data}, 9'h000);
    check("rst_cpu", {cpu_done, cpu_rdata}, 9'h000);
    check("rst_vram", {vram_we, vram_addr, vram_wdata}, 22'h0);
    rst = 1'b0;
    tick();

    fetch_txn(1'b0, 16'h9800, 2'd3, 1'b0);
    pair_txn(1'b1, 16'h8100, 16'h8200);
    pair_txn(1'b0, 16'h8100, 16'h8200);
    cpu_txn(1'b1, 16'h8010, 8'h55, 2'd3);
    cpu_txn(1'b0, 16'h8010, 8'h00, 2'd0);
    cpu_txn(1'b1, 16'h8010, 8'h55, 2'd0);
    cpu_txn(1'b0, 16'h8010, 8'h00, 2'd0);
    fetch_txn(1'b0, 16'h8400, 2'd3, 1'b1);
    fetch_txn(1'b0, 16'h8400, 2'd0, 1'b0);
    cpu_txn(1'b1, 16'hA000, 8'h77, 2'd0);

    // Reset in the middle of a read: nothing of the lost access may surface.
    ppu_mode = 2'd3;
    bg_addr = 16'h8123;
    bg_valid = 1'b1;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    check("midrst_outputs", {bg_data_valid, bg_data, spr_data_valid, cpu_done, vram_we, vram_addr},
          31'h0);
    bg_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    begin
      bit stale;
      stale = 1'b0;
      for (int i = 0; i < 6; i++) begin
        tick();
        stale = stale | bg_data_valid | spr_data_valid | cpu_done;
      end
      check("midrst_no_stale", stale, 1'b0);
    end
    fetch_txn(1'b0, 16'h8123, 2'd3, 1'b0);

    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0: fetch_txn(1'b0, rand_addr(), ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'd3, 1'b0);
        1: fetch_txn(1'b1, rand_addr(), ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'd3, 1'b0);
        2: pair_txn(1'($urandom_range(0, 1)), rand_addr(), rand_addr());
        default: cpu_txn(1'($urandom_range(0, 1)), rand_addr(), 8'($urandom),
                         ($urandom_range(0, 3) == 0) ? 2'd3 : 2'($urandom_range(0, 2)));
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
